// File: rtl/window_framer.sv
// window_framer: collects a serial sample stream into overlapping windows of
// WIN_LEN samples, one new window every HOP accepted samples, and presents each
// completed window in parallel with a one-cycle ready pulse.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FILL  | first window after reset/restart still being collected
// ST_SLIDE | first window done; a window is emitted every HOP samples
module window_framer #(
   parameter int DATA_W  = 12,
   parameter int WIN_LEN = 256,
   parameter int HOP     = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   input  logic              enable,
   input  logic              restart,
   output logic [DATA_W-1:0] window_out [WIN_LEN-1:0],
   output logic              window_ready,
   output logic [15:0]       frame_count,
   output logic              filling
);

   localparam int               CNT_W     = $clog2(WIN_LEN + 1);
   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WIN_LEN - 1);
   localparam logic [CNT_W-1:0] HOP_LAST  = CNT_W'(HOP - 1);

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_SLIDE = 1'b1
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] sh_q  [WIN_LEN-1:0];
   logic [DATA_W-1:0] sh_d  [WIN_LEN-1:0];
   logic [DATA_W-1:0] win_q [WIN_LEN-1:0];
   logic              ready_q;
   logic [15:0]       fc_q;
   logic              accept;
   logic              complete;

   // restart beats a sample arriving in the same cycle, so it also blocks accept
   assign accept   = sample_valid & enable & ~restart;
   assign complete = accept & ((state_q == ST_FILL) ? (cnt_q == FILL_LAST)
                                                    : (cnt_q == HOP_LAST));

   // Shift register contents after accepting sample_in; also the emitted window
   always_comb begin
      for (int i = 0; i < WIN_LEN - 1; i++) begin
         sh_d[i] = sh_q[i+1];
      end
      sh_d[WIN_LEN-1] = sample_in;
   end

   // Collection FSM with registered window, ready strobe and frame counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_FILL;
         cnt_q   <= '0;
         sh_q    <= '{default: '0};
         win_q   <= '{default: '0};
         ready_q <= 1'b0;
         fc_q    <= '0;
      end else if (restart) begin
         state_q <= ST_FILL;
         cnt_q   <= '0;
         sh_q    <= '{default: '0};
         win_q   <= '{default: '0};
         ready_q <= 1'b0;
         fc_q    <= '0;
      end else if (accept) begin
         sh_q <= sh_d;
         if (complete) begin
            win_q   <= sh_d;
            ready_q <= 1'b1;
            fc_q    <= fc_q + 16'd1;
            cnt_q   <= '0;
            state_q <= ST_SLIDE;
         end else begin
            ready_q <= 1'b0;
            cnt_q   <= cnt_q + CNT_W'(1);
         end
      end else begin
         ready_q <= 1'b0;
      end
   end

   assign window_out   = win_q;
   assign window_ready = ready_q;
   assign frame_count  = fc_q;
   assign filling      = (state_q == ST_FILL);

endmodule
